// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_pkg;

  typedef enum logic [0:0] {
    S_GAP,
    S_ON
  } scan_state_e;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam int unsigned SEG_DP = 0;
  localparam int unsigned AN_MAX = 64;

  // All-ones anode mask for a display of the given width (anodes are active-low).
  function automatic logic [AN_MAX-1:0] an_off(input int unsigned width);
    logic [AN_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < AN_MAX; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/bcd_seg.sv
// BCD to 7-segment decoder, segments {a,b,c,d,e,f,g} active-high per digit.
module bcd_seg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH*4-1:0] bcd,
  output logic [WIDTH*7-1:0] seg
);

  always_comb begin
    seg = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case (bcd[i*4 +: 4])
        4'd0:    seg[i*7 +: 7] = 7'b1111110;
        4'd1:    seg[i*7 +: 7] = 7'b0110000;
        4'd2:    seg[i*7 +: 7] = 7'b1101101;
        4'd3:    seg[i*7 +: 7] = 7'b1111001;
        4'd4:    seg[i*7 +: 7] = 7'b0110011;
        4'd5:    seg[i*7 +: 7] = 7'b1011011;
        4'd6:    seg[i*7 +: 7] = 7'b1011111;
        4'd7:    seg[i*7 +: 7] = 7'b1110000;
        4'd8:    seg[i*7 +: 7] = 7'b1111111;
        4'd9:    seg[i*7 +: 7] = 7'b1111011;
        // Out-of-range codes fall back to the '0' glyph.
        default: seg[i*7 +: 7] = 7'b1111110;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display,
// with a shadow buffer that is committed to the display only at frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned SLOT_CYC = 50000,
  parameter int unsigned GAP_CYC  = 500,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH*4-1:0] bcd_in,
  input  logic [WIDTH-1:0]   dp_in,
  input  logic               load,
  output logic               pending,
  output logic               frame_tick,
  output logic [WIDTH-1:0]   an,
  output logic [7:0]         seg
);

  localparam int unsigned CntW = $clog2(SLOT_CYC);
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] AnOff = WIDTH'(an_off(WIDTH));

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  scan_state_e        state_q, state_d;
  logic [WIDTH*4-1:0] shadow_q, shadow_d, disp_q, disp_d;
  logic [WIDTH-1:0]   dp_shadow_q, dp_shadow_d, dp_disp_q, dp_disp_d;
  logic               pending_q, pending_d;
  logic               tick_q;
  logic [WIDTH-1:0]   an_q, an_d;
  logic [7:0]         seg_q, seg_d;

  logic               slot_end, frame_end;
  logic [3:0]         digit;
  logic               dp_bit, blank_cur, zero_run;
  logic [WIDTH-1:0]   blank_vec;
  logic [6:0]         seg7;

  // Scan timing: slot counter, digit index and gap/on phase.
  always_comb begin
    slot_end  = (cnt_q == CntW'(SLOT_CYC - 1));
    frame_end = slot_end && (idx_q == IdxW'(WIDTH - 1));
    cnt_d     = slot_end ? '0 : cnt_q + CntW'(1);
    idx_d     = idx_q;
    if (slot_end) idx_d = (idx_q == IdxW'(WIDTH - 1)) ? '0 : idx_q + IdxW'(1);
    state_d = state_q;
    unique case (state_q)
      S_GAP:   if (cnt_q == CntW'(GAP_CYC - 1)) state_d = S_ON;
      S_ON:    if (slot_end) state_d = S_GAP;
      default: state_d = S_GAP;
    endcase
  end

  // Shadow/display buffers; load data on the boundary cycle beats the shadow.
  always_comb begin
    shadow_d    = shadow_q;
    dp_shadow_d = dp_shadow_q;
    disp_d      = disp_q;
    dp_disp_d   = dp_disp_q;
    pending_d   = pending_q;
    if (load) begin
      shadow_d    = bcd_in;
      dp_shadow_d = dp_in;
      pending_d   = 1'b1;
    end
    if (frame_end) begin
      pending_d = 1'b0;
      if (load) begin
        disp_d    = bcd_in;
        dp_disp_d = dp_in;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        dp_disp_d = dp_shadow_q;
      end
    end
  end

  // Digit mux and leading-zero mask; digit 0 is never blanked.
  always_comb begin
    digit     = '0;
    dp_bit    = 1'b0;
    blank_cur = 1'b0;
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int i = int'(WIDTH) - 1; i >= 1; i--) begin
      zero_run     = zero_run && (disp_q[i*4 +: 4] == 4'd0);
      blank_vec[i] = zero_run;
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (idx_q == IdxW'(i)) begin
        digit     = disp_q[i*4 +: 4];
        dp_bit    = dp_disp_q[i];
        blank_cur = BLANK_LZ && blank_vec[i];
      end
    end
  end

  bcd_seg #(
    .WIDTH(1)
  ) u_dec (
    .bcd(digit),
    .seg(seg7)
  );

  always_comb begin
    an_d  = AnOff;
    seg_d = SEG_BLANK;
    if (state_q == S_ON && !blank_cur) begin
      an_d          = ~(WIDTH'(1) << idx_q);
      seg_d         = {seg7, 1'b0};
      seg_d[SEG_DP] = seg_d[SEG_DP] | dp_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      state_q     <= S_GAP;
      shadow_q    <= '0;
      dp_shadow_q <= '0;
      disp_q      <= '0;
      dp_disp_q   <= '0;
      pending_q   <= 1'b0;
      tick_q      <= 1'b0;
      an_q        <= AnOff;
      seg_q       <= SEG_BLANK;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      dp_shadow_q <= dp_shadow_d;
      disp_q      <= disp_d;
      dp_disp_q   <= dp_disp_d;
      pending_q   <= pending_d;
      tick_q      <= frame_end;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign pending    = pending_q;
  assign frame_tick = tick_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (leading-zero blanking off/on) on shared stimulus,
// checked every cycle against a frame-position model plus table vectors and corner sequences.
module tb_seg_scan_ctrl;

  localparam int W     = 4;
  localparam int SLOT  = 8;
  localparam int GAP   = 2;
  localparam int FRAME = W * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  an0, an1;
  logic [7:0]  seg0, seg1;
  logic        pend0, pend1, tick0, tick1;

  seg_scan_ctrl #(.WIDTH(W), .SLOT_CYC(SLOT), .GAP_CYC(GAP), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .pending(pend0), .frame_tick(tick0), .an(an0), .seg(seg0)
  );

  seg_scan_ctrl #(.WIDTH(W), .SLOT_CYC(SLOT), .GAP_CYC(GAP), .BLANK_LZ(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .pending(pend1), .frame_tick(tick1), .an(an1), .seg(seg1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: n = clock edges since the last reset edge; the output after edge n shows frame position n-1.
  int          n = 0;
  logic [15:0] mdisp = '0, mshadow = '0;
  logic [3:0]  mdp = '0, mdpsh = '0;
  logic        mpend = 1'b0;
  logic [3:0]  exp_an [2];
  logic [7:0]  exp_seg[2];
  logic        exp_pend, exp_tick;

  typedef struct packed {
    logic [15:0]     bcd;
    logic [3:0]      dp;
    logic [3:0][7:0] s0;  // expected seg per slot, blanking off
    logic [3:0][7:0] s1;  // expected seg per slot, blanking on
  } vec_t;
  vec_t vecs[8];

  function automatic logic [7:0] decode(input logic [3:0] v);
    case (v)
      4'd0: return 8'hFC;  4'd1: return 8'h60;  4'd2: return 8'hDA;  4'd3: return 8'hF2;
      4'd4: return 8'h66;  4'd5: return 8'hB6;  4'd6: return 8'hBE;  4'd7: return 8'hE0;
      4'd8: return 8'hFE;  4'd9: return 8'hF6;
      default: return 8'hFC;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic ld, input logic [15:0] b,
                            input logic [3:0] d);
    int pos, slot, c;
    logic blank, lit;
    if (r) begin
      n = 0; mdisp = '0; mshadow = '0; mdp = '0; mdpsh = '0; mpend = 1'b0;
      for (int lz = 0; lz < 2; lz++) begin
        exp_an[lz] = 4'hF; exp_seg[lz] = 8'h00;
      end
      exp_tick = 1'b0;
    end else begin
      pos  = n % FRAME;
      slot = pos / SLOT;
      c    = pos % SLOT;
      for (int lz = 0; lz < 2; lz++) begin
        blank = (lz == 1) && (slot != 0) && ((mdisp >> (4 * slot)) == 16'h0);
        lit   = (c >= GAP) && !blank;
        exp_an[lz]  = lit ? ~(4'b0001 << slot) : 4'hF;
        exp_seg[lz] = lit ? (decode(mdisp[4*slot +: 4]) | {7'b0, mdp[slot]}) : 8'h00;
      end
      exp_tick = (pos == FRAME - 1);
      if (pos == FRAME - 1) begin
        if (ld) begin
          mdisp = b; mdp = d;
        end else if (mpend) begin
          mdisp = mshadow; mdp = mdpsh;
        end
      end
      if (ld) begin
        mshadow = b; mdpsh = d;
        mpend = 1'b1;
      end
      if (pos == FRAME - 1) mpend = 1'b0;
      n++;
    end
    exp_pend = mpend;
  endtask

  task automatic step(input logic r, input logic ld, input logic [15:0] b, input logic [3:0] d);
    rst = r; load = ld; bcd_in = b; dp_in = d;
    @(posedge clk);
    model_edge(r, ld, b, d);
    #1;
    check("an_lz0", {28'h0, an0}, {28'h0, exp_an[0]});
    check("seg_lz0", {24'h0, seg0}, {24'h0, exp_seg[0]});
    check("an_lz1", {28'h0, an1}, {28'h0, exp_an[1]});
    check("seg_lz1", {24'h0, seg1}, {24'h0, exp_seg[1]});
    check("pending", {30'h0, pend1, pend0}, {30'h0, exp_pend, exp_pend});
    check("frame_tick", {30'h0, tick1, tick0}, {30'h0, exp_tick, exp_tick});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic wait_pos(input int target);
    while (n % FRAME != target) idle();
  endtask

  task automatic apply_vec(input vec_t v);
    int p, slot;
    logic [7:0] e0, e1;
    wait_pos(10);
    step(1'b0, 1'b1, v.bcd, v.dp);
    wait_pos(0);
    for (int k = 0; k < FRAME; k++) begin
      idle();
      p = n - 1;
      if (p % SLOT == 4) begin
        slot = (p / SLOT) % W;
        e0 = v.s0[slot];
        e1 = v.s1[slot];
        check("vec_seg_lz0", {24'h0, seg0}, {24'h0, e0});
        check("vec_seg_lz1", {24'h0, seg1}, {24'h0, e1});
        check("vec_an_lz0", {28'h0, an0}, (e0 == 8'h00) ? 32'hF : {28'h0, ~(4'b0001 << slot)});
        check("vec_an_lz1", {28'h0, an1}, (e1 == 8'h00) ? 32'hF : {28'h0, ~(4'b0001 << slot)});
      end
    end
  endtask

  initial begin
    int first;
    logic saw_a;

    vecs[0] = '{bcd: 16'h1234, dp: 4'h0, s0: {8'h60, 8'hDA, 8'hF2, 8'h66},
                s1: {8'h60, 8'hDA, 8'hF2, 8'h66}};
    vecs[1] = '{bcd: 16'h0050, dp: 4'h0, s0: {8'hFC, 8'hFC, 8'hB6, 8'hFC},
                s1: {8'h00, 8'h00, 8'hB6, 8'hFC}};
    vecs[2] = '{bcd: 16'h0000, dp: 4'h0, s0: {8'hFC, 8'hFC, 8'hFC, 8'hFC},
                s1: {8'h00, 8'h00, 8'h00, 8'hFC}};
    vecs[3] = '{bcd: 16'h0C00, dp: 4'h0, s0: {8'hFC, 8'hFC, 8'hFC, 8'hFC},
                s1: {8'h00, 8'hFC, 8'hFC, 8'hFC}};
    vecs[4] = '{bcd: 16'h000C, dp: 4'h1, s0: {8'hFC, 8'hFC, 8'hFC, 8'hFD},
                s1: {8'h00, 8'h00, 8'h00, 8'hFD}};
    vecs[5] = '{bcd: 16'h9999, dp: 4'h0, s0: {8'hF6, 8'hF6, 8'hF6, 8'hF6},
                s1: {8'hF6, 8'hF6, 8'hF6, 8'hF6}};
    vecs[6] = '{bcd: 16'h8765, dp: 4'hF, s0: {8'hFF, 8'hE1, 8'hBF, 8'hB7},
                s1: {8'hFF, 8'hE1, 8'hBF, 8'hB7}};
    vecs[7] = '{bcd: 16'h0007, dp: 4'hE, s0: {8'hFD, 8'hFD, 8'hFD, 8'hE0},
                s1: {8'h00, 8'h00, 8'h00, 8'hE0}};

    // Reset held for three cycles, then the first frame_tick lands 32 cycles after release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
    check("rst_an", {28'h0, an0}, 32'hF);
    check("rst_seg", {24'h0, seg0}, 32'h0);
    check("rst_pending", {31'h0, pend0}, 32'h0);
    check("rst_tick", {31'h0, tick0}, 32'h0);
    first = 0;
    for (int i = 1; i <= 100; i++) begin
      idle();
      if (tick0 === 1'b1) begin
        first = i;
        break;
      end
    end
    check("first_tick_cycle", first, 32);

    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // Two loads before one boundary: only the second is ever displayed.
    wait_pos(5);
    step(1'b0, 1'b1, 16'h1111, 4'h0);
    for (int i = 0; i < 3; i++) idle();
    step(1'b0, 1'b1, 16'h2222, 4'h0);
    wait_pos(0);
    saw_a = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      idle();
      if (seg0 == 8'h60 || seg1 == 8'h60) saw_a = 1'b1;
      if ((n - 1) % FRAME == 4) check("ab_slot0", {24'h0, seg0}, 32'hDA);
    end
    check("ab_first_never_shown", {31'h0, saw_a}, 32'h0);

    // Load on the boundary cycle itself.
    wait_pos(FRAME - 1);
    step(1'b0, 1'b1, 16'h9999, 4'h0);
    check("bnd_pending", {31'h0, pend0}, 32'h0);
    check("bnd_tick", {31'h0, tick0}, 32'h1);
    for (int i = 0; i < 5; i++) idle();
    check("bnd_slot0_seg", {24'h0, seg0}, 32'hF6);
    check("bnd_slot0_an", {28'h0, an0}, 32'hE);

    // Reset in the middle of slot 2's on-phase with a load still pending.
    wait_pos(17);
    step(1'b0, 1'b1, 16'h4321, 4'h0);
    wait_pos(20);
    check("mid_an_pre", {28'h0, an0}, 32'hB);
    check("mid_pend_pre", {31'h0, pend0}, 32'h1);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    check("mid_rst_an", {28'h0, an0}, 32'hF);
    check("mid_rst_seg", {24'h0, seg0}, 32'h0);
    check("mid_rst_pend", {31'h0, pend0}, 32'h0);
    for (int i = 0; i < 5; i++) idle();
    check("mid_restart_an", {28'h0, an0}, 32'hE);
    check("mid_restart_seg", {24'h0, seg0}, 32'hFC);

    // Random traffic with sparse nonzero digits to exercise blanking.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] b;
      for (int j = 0; j < 4; j++) b[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0), b, 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
